// File: rtl/ex_stage_pipe.sv
// Execute stage for the RV64I-subset core: ALU, load/store address, branch resolve and an
// iterative shift-add multiplier, feeding a single valid/ready output slot.
module ex_stage_pipe #(
    parameter int         XLEN       = 64,
    parameter int         DMEM_AW    = 10,
    parameter int         MUL_STEP   = 1,
    parameter logic [6:0] EOF_OPCODE = 7'b1111111
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [1:0]      o_kind,
    output logic            o_wb_en,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic            o_br_taken,
    output logic [XLEN-1:0] o_br_target,
    output logic            o_illegal,
    output logic            o_finish
);

    localparam int SHW        = $clog2(XLEN);
    localparam int MUL_CYCLES = XLEN / MUL_STEP;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);

    localparam logic [1:0] KIND_ALU    = 2'd0;
    localparam logic [1:0] KIND_LOAD   = 2'd1;
    localparam logic [1:0] KIND_STORE  = 2'd2;
    localparam logic [1:0] KIND_BRANCH = 2'd3;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t state_q, state_d;

    logic            valid_q, valid_d;
    logic [1:0]      kind_q, kind_d;
    logic            wb_en_q, wb_en_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic            br_taken_q, br_taken_d;
    logic [XLEN-1:0] br_target_q, br_target_d;
    logic            illegal_q, illegal_d;
    logic            finish_q, finish_d;

    logic [XLEN-1:0] mul_acc_q, mul_acc_d;
    logic [XLEN-1:0] mul_mcand_q, mul_mcand_d;
    logic [XLEN-1:0] mul_mplier_q, mul_mplier_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [4:0]      mul_rd_q, mul_rd_d;

    // ---------------- decode ----------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      dec_rd;
    logic            rd_nz;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign dec_rd = i_inst[11:7];
    assign rd_nz  = (dec_rd != 5'd0);
    assign imm_i  = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign imm_s  = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b  = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};

    logic [1:0] dec_kind;
    logic       dec_illegal;
    logic       dec_is_mul;
    logic       dec_is_eof;

    always_comb begin
        dec_kind    = KIND_ALU;
        dec_illegal = 1'b0;
        dec_is_mul  = 1'b0;
        dec_is_eof  = 1'b0;
        if (opcode == EOF_OPCODE) begin
            dec_is_eof = 1'b1;
        end else begin
            case (opcode)
                OP_IMM: dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
                OP_REG: begin
                    if (funct7 == 7'b0000001) begin
                        dec_is_mul  = (funct3 == 3'b000);
                        dec_illegal = (funct3 != 3'b000);
                    end else if (funct7 == 7'b0000000) begin
                        dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
                    end else if (funct7 == 7'b0100000) begin
                        dec_illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OP_LOAD:  dec_kind = KIND_LOAD;
                OP_STORE: dec_kind = KIND_STORE;
                OP_BRANCH: begin
                    dec_kind    = KIND_BRANCH;
                    dec_illegal = (funct3[1] == 1'b1);
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // ---------------- single-cycle datapath ----------------
    logic [XLEN-1:0] alu_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sra_result;
    logic [XLEN-1:0] alu_result;

    assign alu_b      = (opcode == OP_IMM) ? imm_i : i_rs2;
    assign shamt      = alu_b[SHW-1:0];
    assign sra_result = $signed(i_rs1) >>> shamt;

    always_comb begin
        alu_result = i_rs1;
        case (funct3)
            3'b000: alu_result = ((opcode == OP_REG) && i_inst[30]) ? (i_rs1 - alu_b) : (i_rs1 + alu_b);
            3'b001: alu_result = i_rs1 << shamt;
            3'b100: alu_result = i_rs1 ^ alu_b;
            3'b101: alu_result = i_inst[30] ? sra_result : (i_rs1 >> shamt);
            3'b110: alu_result = i_rs1 | alu_b;
            3'b111: alu_result = i_rs1 & alu_b;
            default: alu_result = i_rs1;
        endcase
    end

    // Address add touches only the data-memory index field; its carry is discarded.
    logic [XLEN-1:0]    mem_imm;
    logic [DMEM_AW-1:0] mem_low;
    logic [XLEN-1:0]    mem_addr;

    assign mem_imm  = (opcode == OP_STORE) ? imm_s : imm_i;
    assign mem_low  = i_rs1[DMEM_AW-1:0] + mem_imm[DMEM_AW-1:0];
    assign mem_addr = {i_rs1[XLEN-1:DMEM_AW], mem_low};

    logic br_eq, br_lt, br_taken;
    assign br_eq    = (i_rs1 == i_rs2);
    assign br_lt    = ($signed(i_rs1) < $signed(i_rs2));
    assign br_taken = funct3[2] ? (br_lt ^ funct3[0]) : (br_eq ^ funct3[0]);

    logic unused_ok;
    assign unused_ok = &{1'b0, i_inst[19:15], mem_imm[XLEN-1:DMEM_AW]};

    // ---------------- multiplier step ----------------
    logic [XLEN-1:0] mul_sum;
    logic            mul_last;

    always_comb begin
        mul_sum = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mul_mplier_q[j]) begin
                mul_sum = mul_sum + (mul_mcand_q << j);
            end
        end
    end

    assign mul_last = (state_q == S_MUL) && (mul_cnt_q == CNT_W'(MUL_CYCLES - 1));

    logic accept;
    assign accept = i_valid & o_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && dec_is_mul) state_d = S_MUL;
            S_MUL:   if (mul_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = i_rst_n & (state_q == S_IDLE) & ~finish_q & (~valid_q | i_ready);
    end

    always_comb begin
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
        mul_rd_d     = mul_rd_q;
        if (state_q == S_MUL) begin
            mul_acc_d    = mul_acc_q + mul_sum;
            mul_mcand_d  = mul_mcand_q << MUL_STEP;
            mul_mplier_d = mul_mplier_q >> MUL_STEP;
            mul_cnt_d    = mul_cnt_q + CNT_W'(1);
        end else if (accept && dec_is_mul) begin
            mul_acc_d    = '0;
            mul_mcand_d  = i_rs1;
            mul_mplier_d = i_rs2;
            mul_cnt_d    = '0;
            mul_rd_d     = dec_rd;
        end
    end

    // ---------------- output slot ----------------
    always_comb begin
        valid_d     = valid_q & ~i_ready;
        kind_d      = kind_q;
        wb_en_d     = wb_en_q;
        rd_d        = rd_q;
        result_d    = result_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        illegal_d   = illegal_q;
        finish_d    = finish_q;

        if (accept) begin
            if (dec_is_eof) begin
                finish_d = 1'b1;
            end else if (dec_illegal) begin
                valid_d   = 1'b1;
                illegal_d = 1'b1;
                wb_en_d   = 1'b0;
                kind_d    = KIND_ALU;
            end else if (!dec_is_mul) begin
                valid_d   = 1'b1;
                illegal_d = 1'b0;
                kind_d    = dec_kind;
                case (dec_kind)
                    KIND_ALU: begin
                        wb_en_d  = rd_nz;
                        rd_d     = dec_rd;
                        result_d = alu_result;
                    end
                    KIND_LOAD: begin
                        wb_en_d    = rd_nz;
                        rd_d       = dec_rd;
                        mem_addr_d = mem_addr;
                    end
                    KIND_STORE: begin
                        wb_en_d     = 1'b0;
                        mem_addr_d  = mem_addr;
                        mem_wdata_d = i_rs2;
                    end
                    default: begin
                        wb_en_d     = 1'b0;
                        br_taken_d  = br_taken;
                        br_target_d = i_pc + imm_b;
                    end
                endcase
            end
        end

        // The slot is guaranteed empty here: a MUL is only accepted when the slot drains.
        if (mul_last) begin
            valid_d   = 1'b1;
            illegal_d = 1'b0;
            kind_d    = KIND_ALU;
            wb_en_d   = (mul_rd_q != 5'd0);
            rd_d      = mul_rd_q;
            result_d  = mul_acc_q + mul_sum;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            kind_q       <= '0;
            wb_en_q      <= 1'b0;
            rd_q         <= '0;
            result_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            illegal_q    <= 1'b0;
            finish_q     <= 1'b0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
            mul_rd_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            kind_q       <= kind_d;
            wb_en_q      <= wb_en_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            illegal_q    <= illegal_d;
            finish_q     <= finish_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
            mul_rd_q     <= mul_rd_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_kind      = kind_q;
    assign o_wb_en     = wb_en_q;
    assign o_rd        = rd_q;
    assign o_result    = result_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_br_taken  = br_taken_q;
    assign o_br_target = br_target_q;
    assign o_illegal   = illegal_q;
    assign o_finish    = finish_q;

endmodule
